// File: rtl/gonso_wb_initiator.sv
// gonso_wb_initiator: command-driven Wishbone initiator issuing single or incrementing
// burst transfers, one response per word, with an ack timeout that abandons the burst.
module gonso_wb_initiator #(
  parameter int TMO_CYCLES = 16,
  parameter int TSIZE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  input  logic [3:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2;
  localparam logic [TSIZE-1:0] TMO_LAST = TSIZE'(TMO_CYCLES - 1);
  logic [1:0] state;
  logic [3:0] len, word;
  logic [TSIZE-1:0] tmo;
  logic last_word, tmo_hit;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign last_word = word == len;
  // ack in the final allowed cycle is handled first, so it wins over the timeout
  assign tmo_hit = (TMO_CYCLES != 0) && (tmo == TMO_LAST);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      word <= '0;
      tmo <= '0;
      rsp_valid <= 1'b0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
      rsp_last <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
    end else
      case (state)
        IDLE: if (cmd_valid) begin
          state <= REQ;
          len <= cmd_len;
          word <= '0;
          tmo <= '0;
          wbm_we_o <= cmd_we;
          wbm_adr_o <= cmd_adr;
          wbm_dat_o <= cmd_dat;
          wbm_sel_o <= cmd_sel;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
        end
        REQ: if (wbm_ack_i) begin
          state <= RSP;
          wbm_stb_o <= 1'b0;
          wbm_cyc_o <= !last_word;
          rsp_valid <= 1'b1;
          rsp_dat <= wbm_we_o ? 32'd0 : wbm_dat_i;
          rsp_err <= 1'b0;
          rsp_last <= last_word;
        end else if (tmo_hit) begin
          state <= RSP;
          wbm_stb_o <= 1'b0;
          wbm_cyc_o <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_dat <= '0;
          rsp_err <= 1'b1;
          rsp_last <= 1'b1;
        end else
          tmo <= (&tmo) ? tmo : tmo + 1'b1;
        RSP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (rsp_last) begin
            state <= IDLE;
            wbm_cyc_o <= 1'b0;
          end else begin
            state <= REQ;
            word <= word + 4'd1;
            tmo <= '0;
            wbm_adr_o <= wbm_adr_o + 32'd4;
            wbm_stb_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/gonso_wb_initiator.md
# gonso_wb_initiator

Command-driven Wishbone initiator that issues single-word or incrementing multi-word read/write transactions toward Wishbone responders such as the gonso register block. It sits between an internal command source and the Wishbone bus. It provides a valid/ready command port, a valid/ready response port, and an ack timeout that aborts transfers to non-responding addresses.

## Interface
- TMO_CYCLES, 16: maximum cycles stb is held waiting for ack; 0 disables the timeout.
- TSIZE, 8: width of the timeout counter; TMO_CYCLES < 2^TSIZE.
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accept, high only in IDLE
- cmd_we  in  1  1: write, 0: read
- cmd_adr  in  32  start byte address, word aligned
- cmd_dat  in  32  write data, used for every word of a write burst
- cmd_sel  in  4  byte enables, used for every word
- cmd_len  in  4  word count minus one (0 → 1 word, 15 → 16 words)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_dat  out  32  read data; 0 for writes and errors
- rsp_err  out  1  ack timeout on this word
- rsp_last  out  1  final response of the command
- busy  out  1  high when not in IDLE
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe, write
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_sel_o  out  4  Wishbone byte select
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

## Operation
- **States:** IDLE, REQ, RSP.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch we/adr/dat/sel/len, clear the word counter, and go to REQ.
- **REQ:**
  - cyc=stb=1; adr = start + 4·word, wrapping modulo 2^32.
  - On wbm_ack_i: capture rsp_dat (wbm_dat_i if read, else 0), set rsp_err=0, drop stb, and go to RSP.
  - Timeout: stb high for TMO_CYCLES cycles with no ack → drop cyc and stb, set rsp_err=1, rsp_dat=0, rsp_last=1, go to RSP. Remaining words are abandoned.
  - An ack sampled in the last allowed cycle wins over the timeout.
- **RSP:**
  - rsp_valid=1; stb=0; cyc stays 1 unless this is the last word or an error.
  - rsp_last=1 when word==len or on error.
  - On rsp_ready:
    - If last: drop cyc and go to IDLE.
    - Otherwise: word+1 and go to REQ.
- wbm_ack_i outside REQ is ignored.
- Output payload (wbm_adr_o/dat_o/sel_o/we_o, rsp_*) is stable while its valid/stb is high.
- **Reset (any time, including mid-burst):** state IDLE.
  - cyc, stb, we, rsp_valid, rsp_err, rsp_last, busy = 0.
  - adr, dat, sel, rsp_dat = 0.
  - cmd_ready=1.
  - Counters cleared.

## Timing
- All outputs registered, except cmd_ready and busy, which are decoded from the state register.
- Command accepted at cycle T0; stb high at T0+1.
- Ack sampled at cycle Ta; stb low and rsp_valid high at Ta+1.
- Against the gonso register block (ack one cycle after strobe), a single read gives stb at T1, ack at T2, rsp_valid at T3.
- stb is never high in two consecutive words without at least one low cycle between them; this is required because the responder deasserts ack only after it sees stb drop.
- On the last response handshake at cycle Tr: cyc low and cmd_ready high at Tr+1, so the next command is accepted no earlier than Tr+1.
- rsp_valid is held indefinitely under rsp_ready=0; no further bus activity occurs while it is held.
- Timeout counter: cleared on entry to REQ, increments each REQ cycle without ack, saturates at TSIZE bits.

## Test plan
- **Single read:** cmd adr=0x30030004, len=0, we=0; responder acks one cycle after stb with 0x12345678 → stb high exactly T1..T2, rsp_valid at T3 with rsp_dat=0x12345678, rsp_last=1, rsp_err=0.
- **Write burst:** adr=0x30030004, len=2, dat=0xA5A5A5A5, sel=0xF → three writes at 0x…04, 0x…08, 0x…0C, stb low between words, cyc continuous, rsp_last only on the third response.
- **Backpressure:** read len=1, rsp_ready held low 5 cycles after the first response → rsp_valid and rsp_dat stable for those cycles, no second stb until the handshake.
- **Timeout:** responder never acks, TMO_CYCLES=16 → stb high exactly 16 cycles, then rsp_err=1, rsp_last=1, rsp_dat=0, cyc low; the next command is accepted normally.
- **Address wrap:** adr=0xFFFFFFFC, len=1 → second access at 0x00000000.
- **Reset mid-burst:** rst_n low while in REQ of word 1 of a len=3 burst → cyc, stb and rsp_valid go 0 immediately; cmd_ready=1 after reset; a fresh command completes correctly.
